// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with single-cycle ops and an iterative
// MUL/DIVU/REMU unit behind valid/ready handshakes on both sides.
module alu_seq #(
  parameter int unsigned XLen         = 32,
  parameter bit          EnableMulDiv = 1'b1,
  parameter int unsigned NOps         = 13,
  localparam int unsigned OpW = $clog2(NOps),
  localparam int unsigned ShW = $clog2(XLen)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLen-1:0] a_i,
  input  logic [XLen-1:0] b_i,
  input  logic [OpW-1:0]  op_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLen-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam int unsigned NCode = 2 ** OpW;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_OR   = 3;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_SLT  = 5;
  localparam int unsigned OP_SLTU = 6;
  localparam int unsigned OP_SLL  = 7;
  localparam int unsigned OP_SRL  = 8;
  localparam int unsigned OP_SRA  = 9;
  localparam int unsigned OP_MUL  = 10;
  localparam int unsigned OP_DIVU = 11;
  localparam int unsigned OP_REMU = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [NCode-1:0] op_oh;
  logic             unused_op;
  logic             accept;
  logic             is_sc;
  logic             is_md;
  logic             illegal;
  logic             md_busy;
  logic             md_last;
  logic [XLen-1:0]  md_res;
  logic [XLen-1:0]  alu_res;
  logic [XLen-1:0]  result_q;
  logic             illegal_q;

  assign op_oh = {{(NCode-1){1'b0}}, 1'b1} << op_i;
  assign unused_op = ^op_oh[NCode-1:OP_SRA+1];

  assign is_sc = |op_oh[OP_SRA:OP_ADD];
  assign is_md = EnableMulDiv
              && (|op_oh[OP_REMU:OP_MUL]);
  assign illegal = !is_sc && !is_md;
  assign accept = in_valid_i && in_ready_o;
  assign md_busy = (state_q == S_BUSY);

  logic [XLen-1:0] sum;
  logic [XLen-1:0] diff;
  logic [XLen:0]   diff_u;
  logic [ShW-1:0]  shamt;
  logic            ovf;
  logic            lt_s;
  logic            lt_u;

  assign shamt = b_i[ShW-1:0];
  assign sum = a_i + b_i;
  assign diff_u = {1'b0, a_i} - {1'b0, b_i};
  assign diff = diff_u[XLen-1:0];
  assign lt_u = diff_u[XLen];
  // Signed less-than: sign of a-b corrected by overflow.
  assign ovf = (a_i[XLen-1] ^ b_i[XLen-1])
             & (diff[XLen-1] ^ a_i[XLen-1]);
  assign lt_s = diff[XLen-1] ^ ovf;

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      op_oh[OP_ADD]:  alu_res = sum;
      op_oh[OP_SUB]:  alu_res = diff;
      op_oh[OP_AND]:  alu_res = a_i & b_i;
      op_oh[OP_OR]:   alu_res = a_i | b_i;
      op_oh[OP_XOR]:  alu_res = a_i ^ b_i;
      op_oh[OP_SLT]:  alu_res = {{(XLen-1){1'b0}}, lt_s};
      op_oh[OP_SLTU]: alu_res = {{(XLen-1){1'b0}}, lt_u};
      op_oh[OP_SLL]:  alu_res = a_i << shamt;
      op_oh[OP_SRL]:  alu_res = a_i >> shamt;
      op_oh[OP_SRA]:
        alu_res = $unsigned($signed(a_i) >>> shamt);
      default:        alu_res = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          state_d = is_md ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (md_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == S_IDLE);
    out_valid_o = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (accept && !is_md) begin
      result_q  <= illegal ? '0 : alu_res;
      illegal_q <= illegal;
    end else if (md_busy && md_last) begin
      result_q  <= md_res;
      illegal_q <= 1'b0;
    end
  end

  assign result_o  = out_valid_o ? result_q : '0;
  assign zero_o    = out_valid_o && (result_q == '0);
  assign illegal_o = out_valid_o && illegal_q;

  if (EnableMulDiv) begin : g_md
    localparam int unsigned CntW = $clog2(XLen);

    logic [XLen-1:0] a_q;
    logic [XLen-1:0] b_q;
    logic [XLen-1:0] acc_q;
    logic [XLen-1:0] a_d;
    logic [XLen-1:0] b_d;
    logic [XLen-1:0] acc_d;
    logic [CntW-1:0] cnt_q;
    logic            mul_q;
    logic            rem_q;
    logic [XLen:0]   rem_sh;
    logic [XLen:0]   rem_diff;
    logic            q_bit;

    // Divide: acc holds the partial remainder, a_q
    // shifts dividend bits out and quotient bits in.
    assign rem_sh = {acc_q, a_q[XLen-1]};
    assign rem_diff = rem_sh - {1'b0, b_q};
    assign q_bit = ~rem_diff[XLen];

    always_comb begin
      if (mul_q) begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
      end else begin
        acc_d = q_bit ? rem_diff[XLen-1:0]
                      : rem_sh[XLen-1:0];
        a_d   = {a_q[XLen-2:0], q_bit};
        b_d   = b_q;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_q   <= '0;
        b_q   <= '0;
        acc_q <= '0;
        cnt_q <= '0;
        mul_q <= 1'b0;
        rem_q <= 1'b0;
      end else if (accept && is_md) begin
        a_q   <= a_i;
        b_q   <= b_i;
        acc_q <= '0;
        cnt_q <= CntW'(XLen - 1);
        mul_q <= op_oh[OP_MUL];
        rem_q <= op_oh[OP_REMU];
      end else if (md_busy) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
        cnt_q <= cnt_q - CntW'(1);
      end
    end

    assign md_last = (cnt_q == '0);
    assign md_res  = (mul_q || rem_q) ? acc_d : a_d;
  end else begin : g_no_md
    logic unused_busy;
    assign unused_busy = md_busy;
    assign md_last = 1'b1;
    assign md_res  = '0;
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with literal expectations plus a
// cycle-level reference model checked every negedge.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [3:0]  op_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        zero_o;
  logic        illegal_o;

  logic        nm_valid = 1'b0;
  logic        nm_ready = 1'b0;
  logic        nm_in_ready;
  logic        nm_out_valid;
  logic [31:0] nm_result;
  logic        nm_zero;
  logic        nm_illegal;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_i        (op_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .zero_o      (zero_o),
    .illegal_o   (illegal_o)
  );

  alu_seq #(.EnableMulDiv(1'b0)) u_nomd (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (nm_valid),
    .in_ready_o  (nm_in_ready),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_i        (op_i),
    .out_valid_o (nm_out_valid),
    .out_ready_i (nm_ready),
    .result_o    (nm_result),
    .zero_o      (nm_zero),
    .illegal_o   (nm_illegal)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    logic [31:0] r;
    logic ill;
    r = '0;
    ill = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  r = (a < b) ? 32'd1 : 32'd0;
      4'd7:  r = a << b[4:0];
      4'd8:  r = a >> b[4:0];
      4'd9:  r = $unsigned($signed(a) >>> b[4:0]);
      4'd10: r = a * b;
      4'd11: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: r = (b == 0) ? a : a % b;
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    return (op >= 4'd10 && op <= 4'd12) ? 33 : 1;
  endfunction

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          due;
  } exp_t;

  exp_t q[$];

  // Reference model: one op in flight, result due a fixed
  // latency after acceptance, held until the consumer takes it.
  always @(negedge clk) begin
    bit rdy;
    bit vld;
    logic [32:0] m;
    exp_t e;
    cyc++;
    if (!rst_ni) begin
      q.delete();
      check("rst_in_ready", 32'(in_ready_o), 32'd1);
      check("rst_out_valid", 32'(out_valid_o), 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_zero", 32'(zero_o), 32'd0);
      check("rst_illegal", 32'(illegal_o), 32'd0);
    end else begin
      rdy = (q.size() == 0);
      vld = 1'b0;
      if (!rdy) vld = (cyc >= q[0].due);
      check("m_in_ready", 32'(in_ready_o), 32'(rdy));
      check("m_out_valid", 32'(out_valid_o), 32'(vld));
      if (vld) begin
        check("m_result", result_o, q[0].res);
        check("m_zero", 32'(zero_o), 32'(q[0].res == 0));
        check("m_illegal", 32'(illegal_o), 32'(q[0].ill));
        if (out_ready_i) void'(q.pop_front());
      end else begin
        check("m_zero_idle", 32'(zero_o), 32'd0);
        check("m_illegal_idle", 32'(illegal_o), 32'd0);
      end
      if (rdy && in_valid_i) begin
        m = model(op_i, a_i, b_i);
        e.res = m[31:0];
        e.ill = m[32];
        e.due = cyc + lat_of(op_i);
        q.push_back(e);
      end
    end
  end

  task automatic run_op(input string name,
                        input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input bit ill,
                        input int lat,
                        input int hold);
    int n;
    @(posedge clk); #1;
    op_i = op;
    a_i = a;
    b_i = b;
    in_valid_i = 1'b1;
    out_ready_i = 1'b0;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    op_i = 4'($urandom_range(0, 15));
    n = 1;
    while (!out_valid_o && n < 60) begin
      check({name, "_ready_busy"}, 32'(in_ready_o), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, lat);
    check({name, "_result"}, result_o, exp);
    check({name, "_zero"}, 32'(zero_o), 32'(exp == 0));
    check({name, "_illegal"}, 32'(illegal_o), 32'(ill));
    for (int i = 0; i < hold; i++) begin
      in_valid_i = 1'b1;
      @(posedge clk); #1;
      check({name, "_hold_valid"}, 32'(out_valid_o), 32'd1);
      check({name, "_hold_result"}, result_o, exp);
      check({name, "_hold_ready"}, 32'(in_ready_o), 32'd0);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    check({name, "_drop"}, 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] m;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    #1 rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    run_op("sub_zero", 4'd1, 32'd5, 32'd5, 32'd0, 0, 1, 0);
    run_op("slt_neg", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1, 0);
    run_op("sltu_neg", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1, 0);
    run_op("slt_ovf", 4'd5, 32'h8000_0000, 32'd1, 32'd1, 0, 1, 0);
    run_op("sra", 4'd9, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1, 0);
    run_op("srl", 4'd8, 32'h8000_0000, 32'h24, 32'h0800_0000, 0, 1, 0);
    run_op("sll", 4'd7, 32'd3, 32'hFFFF_FFE4, 32'h30, 0, 1, 0);
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1, 0);
    run_op("and", 4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0, 1, 0);
    run_op("or", 4'd3, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 0, 1, 0);
    run_op("xor", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 1, 0);
    run_op("sub_hold", 4'd1, 32'd9, 32'd4, 32'd5, 0, 1, 5);
    run_op("mul_ones", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 33, 0);
    run_op("mul", 4'd10, 32'd12345, 32'd1000, 32'd12345000, 0, 33, 0);
    run_op("divu", 4'd11, 32'd100, 32'd7, 32'd14, 0, 33, 5);
    run_op("remu", 4'd12, 32'd100, 32'd7, 32'd2, 0, 33, 0);
    run_op("divu_z", 4'd11, 32'd100, 32'd0, 32'hFFFF_FFFF, 0, 33, 0);
    run_op("remu_z", 4'd12, 32'd100, 32'd0, 32'd100, 0, 33, 0);
    run_op("ill14", 4'd14, 32'd7, 32'd3, 32'd0, 1, 1, 2);
    run_op("ill15", 4'd15, 32'd1, 32'd1, 32'd0, 1, 1, 0);

    for (int i = 0; i < 6; i++) begin
      rop = 4'(10 + (i % 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : 32'($urandom_range(1, 5000));
      m = model(rop, ra, rb);
      run_op("rnd_md", rop, ra, rb, m[31:0], m[32], 33, 0);
    end

    // Back-to-back: valid and ready held high, new operands each cycle.
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    in_valid_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op_i = 4'(i % 10);
      a_i = $urandom;
      b_i = $urandom;
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready_i = 1'b0;

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    op_i = 4'd11;
    a_i = 32'd100;
    b_i = 32'd7;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_ni = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready_o), 32'd1);
    check("abort_out_valid", 32'(out_valid_o), 32'd0);
    check("abort_result", result_o, 32'd0);
    check("abort_zero", 32'(zero_o), 32'd0);
    check("abort_illegal", 32'(illegal_o), 32'd0);
    @(posedge clk);
    #2 rst_ni = 1'b1;
    run_op("divu_after_rst", 4'd11, 32'd100, 32'd7, 32'd14, 0, 33, 0);

    // Build without the multiply/divide unit.
    @(posedge clk); #1;
    op_i = 4'd10;
    a_i = 32'd3;
    b_i = 32'd5;
    nm_valid = 1'b1;
    @(posedge clk); #1;
    nm_valid = 1'b0;
    check("nomd_valid", 32'(nm_out_valid), 32'd1);
    check("nomd_illegal", 32'(nm_illegal), 32'd1);
    check("nomd_result", nm_result, 32'd0);
    check("nomd_ready", 32'(nm_in_ready), 32'd0);
    nm_ready = 1'b1;
    @(posedge clk); #1;
    nm_ready = 1'b0;
    check("nomd_drop", 32'(nm_out_valid), 32'd0);
    check("nomd_zero_idle", 32'(nm_zero), 32'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
